// File: rtl/uart_hex_sequencer.sv
// Turns a byte FIFO into a lowercase hex dump on a UART transmitter:
// two hex digits per byte, then a space or CR LF at frame/line ends.
module uart_hex_sequencer #(
  parameter int unsigned BYTES_PER_LINE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  input  logic       fifo_eof,
  output logic       fifo_rd,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;

  localparam logic [7:0] BPL = 8'(BYTES_PER_LINE);

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) begin
      c = 8'h30 + {4'h0, nib};
    end else begin
      c = 8'h57 + {4'h0, nib};
    end
    return c;
  endfunction

  logic [2:0]      state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic            eof_q, eof_d;
  logic [7:0]      line_cnt_q, line_cnt_d;
  logic [3:0][7:0] char_q, char_d;
  logic [2:0]      q_len_q, q_len_d;
  logic [1:0]      q_idx_q, q_idx_d;
  logic            tx_dv_q, tx_dv_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            busy_q, busy_d;
  logic            fifo_rd_s;
  logic [7:0]      cnt_next_s;
  logic            crlf_s;

  // Next-state and datapath decode for the character sequencer.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    eof_d      = eof_q;
    line_cnt_d = line_cnt_q;
    char_d     = char_q;
    q_len_d    = q_len_q;
    q_idx_d    = q_idx_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    fifo_rd_s  = 1'b0;
    cnt_next_s = line_cnt_q + 8'd1;
    // eof and a full line together still give a single CR LF
    crlf_s     = eof_q || (cnt_next_s >= BPL);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_s = 1'b1;
          byte_d    = fifo_data;
          eof_d     = fifo_eof;
          state_d   = ST_LOAD;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_LOAD: begin
        char_d[0] = hex_char(byte_q[7:4]);
        char_d[1] = hex_char(byte_q[3:0]);
        q_idx_d   = 2'd0;
        if (crlf_s) begin
          char_d[2]  = 8'h0D;
          char_d[3]  = 8'h0A;
          q_len_d    = 3'd4;
          line_cnt_d = 8'd0;
        end else begin
          char_d[2]  = 8'h20;
          char_d[3]  = 8'h00;
          q_len_d    = 3'd3;
          line_cnt_d = cnt_next_s;
        end
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!tx_active) begin
          tx_byte_d = char_q[q_idx_q];
          tx_dv_d   = 1'b1;
          state_d   = ST_WAIT;
        end else begin
          state_d   = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          state_d = ST_NEXT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_NEXT: begin
        if (({1'b0, q_idx_q} + 3'd1) < q_len_q) begin
          q_idx_d = q_idx_q + 2'd1;
          state_d = ST_ISSUE;
        end else begin
          q_idx_d = 2'd0;
          q_len_d = 3'd0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      byte_q     <= 8'h00;
      eof_q      <= 1'b0;
      line_cnt_q <= 8'd0;
      char_q     <= '0;
      q_len_q    <= 3'd0;
      q_idx_q    <= 2'd0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      eof_q      <= eof_d;
      line_cnt_q <= line_cnt_d;
      char_q     <= char_d;
      q_len_q    <= q_len_d;
      q_idx_q    <= q_idx_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
    end
  end

  // The pop is decoded so the head byte is latched in the same cycle it is popped.
  assign fifo_rd = fifo_rd_s & ~reset;
  assign tx_dv   = tx_dv_q;
  assign tx_byte = tx_byte_q;
  assign busy    = busy_q;

endmodule
